// File: rtl/pacman_sprite_render_pkg.sv
// -----------------------------------------------------------------------------
// pacman_pkg
//   Shared types and constants for the Pac-Man sprite renderer.
//   - dir_t   : facing direction as delivered by the movement logic
//   - anim_t  : mouth animation phase
//   - sprite geometry constants and the bitmap generator used to fill the ROM
// -----------------------------------------------------------------------------
package pacman_pkg;

  typedef enum logic [1:0] {
    RIGHT = 2'd0,
    LEFT  = 2'd1,
    UP    = 2'd2,
    DOWN  = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    OPEN   = 2'd0,
    HALF_C = 2'd1,
    CLOSED = 2'd2,
    HALF_O = 2'd3
  } anim_t;

  localparam int SPRITE_SIZE = 16;
  localparam int SCREEN_W    = 640;
  localparam int SCREEN_H    = 480;

  localparam int COORD_W    = 10;
  localparam int RGB_W      = 24;
  localparam int ROM_FRAMES = 3;
  // Address = {frame[1:0], row[3:0], col[3:0]}.
  localparam int ROM_AW     = 10;

  // Bitmap frame used for each animation phase; both half-open phases share
  // the same picture.
  function automatic logic [1:0] anim_frame(input anim_t s);
    case (s)
      OPEN:    return 2'd0;
      CLOSED:  return 2'd2;
      default: return 2'd1;
    endcase
  endfunction

  function automatic anim_t anim_next(input anim_t s);
    case (s)
      OPEN:    return HALF_C;
      HALF_C:  return CLOSED;
      CLOSED:  return HALF_O;
      default: return OPEN;
    endcase
  endfunction

  // Right-facing Pac-Man pixel for frame 0 (90 deg mouth), 1 (45 deg mouth)
  // or 2 (full disc). Coordinates are doubled so the centre (7.5,7.5) lands
  // on the integer 15. A pixel is lit when its centre is within 8 of the
  // disc centre, which keeps the rows/columns that the radius-7.5 circle
  // touches (e.g. the middle of col 0) in the picture.
  // The 45 deg mouth uses tan(22.5 deg) ~= 5/12; for the odd doubled
  // coordinates of a 16x16 sprite that ratio is exact.
  function automatic logic sprite_bit(input int frame, input int row, input int col);
    int   x;
    int   y;
    int   ay;
    logic disc;
    logic mouth;
    x     = 2 * col - (SPRITE_SIZE - 1);
    y     = 2 * row - (SPRITE_SIZE - 1);
    ay    = (y < 0) ? -y : y;
    disc  = (x * x + y * y) < (SPRITE_SIZE * SPRITE_SIZE);
    case (frame)
      0:       mouth = (x > 0) && (ay < x);
      1:       mouth = (x > 0) && (12 * ay < 5 * x);
      default: mouth = 1'b0;
    endcase
    return disc && !mouth;
  endfunction

endpackage

// File: rtl/pacman_sprite_render_if.sv
// -----------------------------------------------------------------------------
// pacman_sprite_render_if
//   Bundle between the movement/scan side and the sprite renderer.
//   Inputs to the renderer (i_*): frame_start pulse, latched position,
//   direction and motion flag, plus the current scan pixel.
//   Outputs of the renderer (o_*): delayed pixel valid, sprite hit, colour.
//   modport master : movement logic / VGA timing side
//   modport slave  : pacman_sprite_render
// -----------------------------------------------------------------------------
interface pacman_sprite_render_if;

  logic                             i_frame_start;
  logic [pacman_pkg::COORD_W-1:0]   i_pac_x;
  logic [pacman_pkg::COORD_W-1:0]   i_pac_y;
  logic [1:0]                       i_dir;
  logic                             i_moving;
  logic                             i_scan_valid;
  logic [pacman_pkg::COORD_W-1:0]   i_scan_x;
  logic [pacman_pkg::COORD_W-1:0]   i_scan_y;
  logic                             o_pix_valid;
  logic                             o_pix_on;
  logic [pacman_pkg::RGB_W-1:0]     o_pix_rgb;

  modport master (
    output i_frame_start, i_pac_x, i_pac_y, i_dir, i_moving,
    output i_scan_valid, i_scan_x, i_scan_y,
    input  o_pix_valid, o_pix_on, o_pix_rgb
  );

  modport slave (
    input  i_frame_start, i_pac_x, i_pac_y, i_dir, i_moving,
    input  i_scan_valid, i_scan_x, i_scan_y,
    output o_pix_valid, o_pix_on, o_pix_rgb
  );

endinterface

// File: rtl/pacman_sprite_rom.sv
// -----------------------------------------------------------------------------
// pacman_sprite_rom
//   3 x 16 x 16 one-bit right-facing Pac-Man bitmap with a registered read.
//   Ports:
//     i_clk  : clock
//     i_rst  : synchronous active-high reset, clears the read register
//     i_addr : {frame[1:0], row[3:0], col[3:0]}; frame 3 reads as blank
//     o_bit  : bitmap bit, one cycle after i_addr
// -----------------------------------------------------------------------------
module pacman_sprite_rom
  import pacman_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [ROM_AW-1:0] i_addr,
  output logic              o_bit
);

  localparam int ROM_DEPTH = 1 << ROM_AW;
  localparam int FRAME_SZ  = SPRITE_SIZE * SPRITE_SIZE;

  function automatic logic [ROM_DEPTH-1:0] build_rom();
    logic [ROM_DEPTH-1:0] bits;
    bits = '0;
    for (int f = 0; f < ROM_FRAMES; f++) begin
      for (int r = 0; r < SPRITE_SIZE; r++) begin
        for (int c = 0; c < SPRITE_SIZE; c++) begin
          bits[f * FRAME_SZ + r * SPRITE_SIZE + c] = sprite_bit(f, r, c);
        end
      end
    end
    return bits;
  endfunction

  localparam logic [ROM_DEPTH-1:0] ROM_BITS = build_rom();

  logic bit_q;

  // NOTE: the bitmap is a constant table and needs no reset; only the read
  // register is cleared so a reset flushes the pixel pipeline.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      bit_q <= 1'b0;
    end else begin
      bit_q <= ROM_BITS[i_addr];
    end
  end

  assign o_bit = bit_q;

endmodule

// File: rtl/pacman_sprite_render.sv
// -----------------------------------------------------------------------------
// pacman_sprite_render
//   Draws the Pac-Man sprite on the VGA scan. Position, direction and motion
//   are latched at each frame start; every scan pixel is tested against the
//   16x16 sprite and reported two cycles later. A 4-phase mouth animation
//   advances every ANIM_DIV moving frames.
//   Parameters:
//     ANIM_DIV : moving frames per animation phase (>= 1)
//     PAC_RGB  : colour driven on sprite pixels
//   Ports:
//     i_clk    : system / pixel clock
//     i_rst    : synchronous active-high reset
//     bus      : pacman_sprite_render_if.slave (position, scan, pixel out)
// -----------------------------------------------------------------------------
module pacman_sprite_render
  import pacman_pkg::*;
#(
  parameter int                ANIM_DIV = 4,
  parameter logic [RGB_W-1:0]  PAC_RGB  = 24'hFFFF00
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  pacman_sprite_render_if.slave bus
);

  localparam int              FC_W    = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(ANIM_DIV - 1);
  localparam logic [COORD_W:0] SPAN   = (COORD_W + 1)'(SPRITE_SIZE);

  // ---------------------------------------------------------------------------
  // Frame-start latch and animation FSM
  // ---------------------------------------------------------------------------
  logic [COORD_W-1:0] px_q, px_d;
  logic [COORD_W-1:0] py_q, py_d;
  dir_t               dir_q, dir_d;
  logic               mov_q, mov_d;
  anim_t              state_q, state_d;
  logic [FC_W-1:0]    fc_q, fc_d;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      px_q    <= '0;
      py_q    <= '0;
      dir_q   <= RIGHT;
      mov_q   <= 1'b0;
      state_q <= OPEN;
      fc_q    <= '0;
    end else begin
      px_q    <= px_d;
      py_q    <= py_d;
      dir_q   <= dir_d;
      mov_q   <= mov_d;
      state_q <= state_d;
      fc_q    <= fc_d;
    end
  end

  // NOTE: every output of this block is given a hold value first, so no
  // path through the ifs can leave one unassigned and infer a latch.
  always_comb begin
    px_d    = px_q;
    py_d    = py_q;
    dir_d   = dir_q;
    mov_d   = mov_q;
    state_d = state_q;
    fc_d    = fc_q;
    if (bus.i_frame_start) begin
      px_d  = bus.i_pac_x;
      py_d  = bus.i_pac_y;
      mov_d = bus.i_moving;
      // A stationary Pac-Man keeps its last facing and a frozen mouth.
      if (bus.i_moving) begin
        dir_d = dir_t'(bus.i_dir);
        if (fc_q == FC_LAST) begin
          fc_d    = '0;
          state_d = anim_next(state_q);
        end else begin
          fc_d = fc_q + 1'b1;
        end
      end
    end
  end

  // The latched motion flag is part of the frame snapshot but nothing in the
  // pixel path depends on it.
  logic mov_unused;
  assign mov_unused = mov_q;

  // ---------------------------------------------------------------------------
  // Stage 1: hit test and ROM address
  // ---------------------------------------------------------------------------
  logic [COORD_W:0]  sx_w, sy_w, px_w, py_w;
  logic              hit_c;
  logic [3:0]        dx_c, dy_c;
  logic [3:0]        row_c, col_c;
  logic [ROM_AW-1:0] addr_c;

  // Widened by one bit so px+16 never wraps: a sprite near the right or
  // bottom edge is clipped rather than reappearing at column/row 0.
  assign sx_w = {1'b0, bus.i_scan_x};
  assign sy_w = {1'b0, bus.i_scan_y};
  assign px_w = {1'b0, px_q};
  assign py_w = {1'b0, py_q};

  assign hit_c = (sx_w >= px_w) && (sx_w < px_w + SPAN) &&
                 (sy_w >= py_w) && (sy_w < py_w + SPAN);

  // Only the low nibble of the offset matters inside the sprite, and it is
  // the difference of the low nibbles modulo 16.
  assign dx_c = bus.i_scan_x[3:0] - px_q[3:0];
  assign dy_c = bus.i_scan_y[3:0] - py_q[3:0];

  // The bitmap faces right; other directions mirror or transpose the lookup.
  always_comb begin
    row_c = dy_c;
    col_c = dx_c;
    case (dir_q)
      RIGHT: begin row_c = dy_c;  col_c = dx_c;         end
      LEFT:  begin row_c = dy_c;  col_c = 4'd15 - dx_c; end
      UP:    begin row_c = dx_c;  col_c = 4'd15 - dy_c; end
      DOWN:  begin row_c = dx_c;  col_c = dy_c;         end
      default: ;
    endcase
  end

  assign addr_c = {anim_frame(state_q), row_c, col_c};

  logic              s1_valid_q, s1_hit_q;
  logic [ROM_AW-1:0] s1_addr_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_valid_q <= 1'b0;
      s1_hit_q   <= 1'b0;
      s1_addr_q  <= '0;
    end else begin
      s1_valid_q <= bus.i_scan_valid;
      s1_hit_q   <= hit_c;
      s1_addr_q  <= addr_c;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: ROM data and pixel result
  // ---------------------------------------------------------------------------
  logic rom_bit;
  logic s2_valid_q, s2_hit_q;

  pacman_sprite_rom u_rom (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_addr (s1_addr_q),
    .o_bit  (rom_bit)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s2_valid_q <= 1'b0;
      s2_hit_q   <= 1'b0;
    end else begin
      s2_valid_q <= s1_valid_q;
      s2_hit_q   <= s1_hit_q;
    end
  end

  // Pure gating of stage-2 registers; no scan input reaches the outputs
  // combinationally.
  logic pix_on;
  assign pix_on = s2_valid_q & s2_hit_q & rom_bit;

  assign bus.o_pix_valid = s2_valid_q;
  assign bus.o_pix_on    = pix_on;
  assign bus.o_pix_rgb   = pix_on ? PAC_RGB : '0;

endmodule

// File: doc/pacman_sprite_render.md
# pacman_sprite_render

Consumes the Pac-Man position produced by the movement logic and draws the sprite on the VGA scan. At each frame start it latches position, facing direction and motion flag. For every scanned pixel it reports whether that pixel lies on the Pac-Man sprite, after a fixed 2-cycle pipeline. It sits between the movement block and the VGA pixel mux, and drives a 4-phase mouth animation.

## Interface
- ANIM_DIV, 4: frames per animation phase step (≥1)
- PAC_RGB, 24'hFFFF00: colour driven on sprite pixels
- i_clk  in  1  system/pixel clock
- i_rst  in  1  reset, synchronous, active-high; one clock (i_clk) for the whole block
- i_frame_start  in  1  one-cycle pulse at start of vertical blank
- i_pac_x  in  10  sprite top-left column, 0..639
- i_pac_y  in  10  sprite top-left row, 0..479
- i_dir  in  2  facing: 0 RIGHT, 1 LEFT, 2 UP, 3 DOWN
- i_moving  in  1  position changed during the last frame
- i_scan_valid  in  1  active-video pixel this cycle
- i_scan_x  in  10  current scan column
- i_scan_y  in  10  current scan row
- o_pix_valid  out  1  i_scan_valid delayed 2 cycles
- o_pix_on  out  1  delayed pixel is on the sprite
- o_pix_rgb  out  24  PAC_RGB when o_pix_on, else 0

## Operation
- Latch on i_frame_start: px/py ← i_pac_x/i_pac_y; dir ← i_dir only if i_moving, otherwise dir holds; mov ← i_moving. New values apply from the next cycle. A scan pixel in the same cycle as i_frame_start uses the old values.
- Animation FSM states: OPEN → HALF_C → CLOSED → HALF_O → OPEN.
  - Frame counter fc counts 0..ANIM_DIV-1 on each i_frame_start with i_moving=1.
  - When fc=ANIM_DIV-1 the FSM advances one state and fc wraps to 0.
  - i_moving=0 freezes both fc and state.
- ROM frame select: OPEN→0; HALF_C and HALF_O→1; CLOSED→2.
- Hit test, computed in 11-bit unsigned: hit = scan_x ≥ px && scan_x < px+16 && scan_y ≥ py && scan_y < py+16.
  - No wrap, so a sprite at px ≥ 625 is clipped at the right edge.
  - dx = scan_x−px and dy = scan_y−py, each 4 bits.
- Orientation. The ROM bitmap faces right.
  - RIGHT: (row,col) = (dy,dx)
  - LEFT: (dy, 15−dx)
  - UP: (dx, 15−dy)
  - DOWN: (dx, dy)
- o_pix_on = stage-2 hit & ROM bit & stage-2 valid.

## Timing
- Stage 1 registers: hit, valid, ROM address {frame[1:0],row[3:0],col[3:0]}.
- Stage 2: ROM data registered; o_pix_* registered outputs.
- Latency is exactly 2 cycles from scan inputs to o_pix_*, with no stalls. There is no backpressure; every cycle is accepted.
- Reset values (next edge after i_rst=1):
  - o_pix_valid=0, o_pix_on=0, o_pix_rgb=0
  - pipeline cleared, state=OPEN, fc=0
  - px=py=0, dir=RIGHT, mov=0
- Reset mid-frame: the pipeline is flushed. Outputs are zero while i_rst is high, and the first valid pixel appears 2 cycles after release.
- i_rst has priority over a simultaneous i_frame_start.

## Structure
- Shared package pacman_pkg holds:
  - dir_t enum (RIGHT, LEFT, UP, DOWN)
  - anim_t enum (OPEN, HALF_C, CLOSED, HALF_O)
  - SPRITE_SIZE=16, SCREEN_W=640, SCREEN_H=480
- Sub-module pacman_sprite_rom:
  - 1-cycle synchronous read of a 3×16×16 1-bit bitmap
  - OPEN = 90° wedge, HALF = 45° wedge, CLOSED = full disc; radius 7.5 centred (7.5,7.5); mouth on the col-15 side.

## Test plan
- Reset: assert i_rst for 3 cycles while scanning → all outputs 0. After release, pixel (8,8) with px=py=0 reports o_pix_on=1 exactly 2 cycles after the scan.
- Position latch: frame_start with pac=(100,200), then scan (107,207) → on=1. Scan (99,207) and (116,207) → on=0. A scan in the frame_start cycle uses the old position.
- Orientation: pac=(0,0), frame OPEN. Scan (15,7) → on=0 for RIGHT and on=1 for LEFT. Scan (7,0) → on=0 for UP and on=1 for DOWN.
- Animation, ANIM_DIV=4, moving=1: 4 frame_starts → HALF_C; 16 → back to OPEN. Scan (14,7) → on=0 at OPEN and on=1 at CLOSED. With moving=0 the state holds and dir is not updated from i_dir.
- Right edge: pac=(630,470). Scan (639,479) → hit evaluated correctly (on=1 only if the ROM bit is set); scan (0,470) → on=0 (no wrap).
- Valid gating: i_scan_valid=0 with coordinates inside the sprite → o_pix_valid=0, on=0, rgb=0.
